div_seq: RTL

- Sequential unsigned restoring divider, one quotient bit per clock.
- Inverse companion of the shift-add multiplier: same start/busy/done handshake and the same IDLE/LOAD/RUN/DONE control style.
- Sits beside the multiplier in the ALU extension.
- Internally split into a control FSM and a shift/subtract datapath.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_control.sv | 82 ++++++++
 rtl/div_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e : 2-bit control state encoding, identical to the shift-add
//                 multiplier's IDLE/LOAD/RUN/DONE sequence.
//   DIV_WIDTH   : default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_control.sv
// Control FSM for the sequential divider.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, honoured only in IDLE
//   cnt_zero      : iteration counter reaches zero at the end of this cycle
//   divisor_zero  : captured divisor is zero
//   ld_operands   : capture dividend/divisor (IDLE with start)
//   clr_rem       : initialise R/Q and the divide-by-zero flag (LOAD)
//   step_enable   : perform one shift/subtract iteration (RUN)
//   cnt_load      : load the iteration counter (LOAD)
//   cnt_dec       : decrement the iteration counter (RUN)
//   busy, done    : status, decoded from state only
module div_control
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic cnt_zero,
  input  logic divisor_zero,
  output logic ld_operands,
  output logic clr_rem,
  output logic step_enable,
  output logic cnt_load,
  output logic cnt_dec,
  output logic busy,
  output logic done
);

  div_state_e state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = divisor_zero ? DONE : RUN;
      RUN:     if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. Only ld_operands looks at an input; busy and done are
  // pure functions of state, so there is no input-to-output path.
  always_comb begin
    ld_operands = 1'b0;
    clr_rem     = 1'b0;
    step_enable = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: ld_operands = start;
      LOAD: begin
        clr_rem  = 1'b1;
        cnt_load = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        step_enable = 1'b1;
        cnt_dec     = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : div_control

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   dividend     : unsigned dividend, captured in the start cycle
//   divisor      : unsigned divisor, captured in the start cycle
//   quotient     : result quotient, held until the next accepted start
//   remainder    : result remainder, held until the next accepted start
//   div_by_zero  : captured divisor was zero
//   busy         : high in LOAD, RUN and DONE
//   done         : one-cycle pulse in DONE
// Latency: done WIDTH+2 cycles after start (2 for a zero divisor).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt;
  logic             dz_reg;

  logic ld_operands, clr_rem, step_enable, cnt_load, cnt_dec;
  logic cnt_zero, divisor_zero;

  logic [WIDTH:0] r_shift, trial;

  assign divisor_zero = (divisor_q == '0);
  // The counter reaches zero on the last of the WIDTH iterations.
  assign cnt_zero     = (cnt == CNT_W'(1));

  // Shift the next dividend bit into R and try subtracting the divisor.
  // R stays below the divisor, so R_shifted < 2*divisor and the WIDTH+1 bit
  // difference has its MSB set exactly when it is negative.
  assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign trial   = r_shift - {1'b0, divisor_q};

  div_control u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cnt_zero     (cnt_zero),
    .divisor_zero (divisor_zero),
    .ld_operands  (ld_operands),
    .clr_rem      (clr_rem),
    .step_enable  (step_enable),
    .cnt_load     (cnt_load),
    .cnt_dec      (cnt_dec),
    .busy         (busy),
    .done         (done)
  );

  // NOTE: all datapath registers are reset, not just control state, because
  // the result outputs are visible and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (ld_operands) begin
      dividend_q <= dividend;
      divisor_q  <= divisor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg  <= '0;
      q_reg  <= '0;
      dz_reg <= 1'b0;
    end else if (clr_rem) begin
      dz_reg <= divisor_zero;
      if (divisor_zero) begin
        // Same answer the iteration would converge to with a zero divisor,
        // produced without spending WIDTH cycles.
        r_reg <= {1'b0, dividend_q};
        q_reg <= '1;
      end else begin
        r_reg <= '0;
        q_reg <= dividend_q;
      end
    end else if (step_enable) begin
      if (!trial[WIDTH]) begin
        r_reg <= trial;
        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        r_reg <= r_shift;
        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (cnt_load) cnt <= CNT_W'(WIDTH);
    else if (cnt_dec)  cnt <= cnt - CNT_W'(1);
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg[WIDTH-1:0];
  assign div_by_zero = dz_reg;

endmodule : div_seq
